// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side drain engine for a FIFO read port. It issues rd_en
//               while the skid buffer has room for the requested word, captures
//               rd_dout one cycle later, and presents the buffered words
//               downstream as a valid/ready stream that holds while stalled.
// Ports       : clk, rst          - read-domain clock, sync active-high reset
//               fifo_empty, rd_en - FIFO status / read strobe
//               rd_dout           - FIFO read data, valid 1 clk after rd_en
//               m_valid, m_data,
//               m_ready           - downstream stream handshake
//               flush             - discard buffered and in-flight words
//               buf_level         - words currently held in the skid buffer
//               xfer_cnt          - words delivered (wraps, cleared by rst)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        rd_dout,
    output logic                         m_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    input  logic                         m_ready,
    input  logic                         flush,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
    output logic [CNT_WIDTH-1:0]         xfer_cnt
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    // One bit wider than the level so level + inflight never overflows.
    localparam logic [c_LVL_W:0] c_DEPTH = BUF_DEPTH[c_LVL_W:0];

    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_xfer_cnt;

    logic [c_LVL_W:0]      w_occupancy;
    logic                  w_push;
    logic                  w_pop;

    // A word already requested still needs a slot, so it counts against room.
    assign w_occupancy = {1'b0, r_level} + {{c_LVL_W{1'b0}}, r_inflight};

    // Deliberately independent of m_ready: requests depend only on registered
    // state and the FIFO flag, keeping the consumer out of the FIFO timing path.
    assign rd_en   = !rst && !flush && !fifo_empty && (w_occupancy < c_DEPTH);

    assign w_push  = r_inflight && !flush;
    assign w_pop   = m_valid && m_ready && !flush;

    assign m_valid   = (r_level != '0);
    assign m_data    = m_valid ? r_buf[r_rd_ptr] : '0;
    assign buf_level = r_level;
    assign xfer_cnt  = r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_inflight <= rd_en;
            if (flush) begin
                // The word landing this cycle is dropped with the rest; the
                // delivered-word count is history and survives a flush.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                    r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + c_LVL_W'(1);
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - c_LVL_W'(1);
                end
            end
        end
    end

    // Storage has no reset; entries are only read once the level covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= rd_dout;
        end
    end

endmodule
`default_nettype wire
